// File: rtl/afe_atten_spi_driver.sv
// CSR-driven 3-wire (CLK/SDI/LE) serializer for the AFE attenuator/switch chains.
// One word per accepted strobe, MSB first, followed by a latch pulse on the addressed chain only.
module afe_atten_spi_driver #(
  parameter int SYSCLK_RATE = 99999001,
  parameter int SPI_RATE    = 5000000,
  parameter int WORD_WIDTH  = 8,
  parameter int CHAIN_COUNT = 2
) (
  input  logic                   sysClk,
  input  logic                   sysReset_n,
  input  logic                   csrStrobe,
  input  logic [31:0]            csrData,
  output logic [31:0]            status,
  output logic [CHAIN_COUNT-1:0] spiClk,
  output logic [CHAIN_COUNT-1:0] spiSdi,
  output logic [CHAIN_COUNT-1:0] spiLe
);

  localparam int HALF_RAW = (SYSCLK_RATE + 2*SPI_RATE - 1) / (2*SPI_RATE);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int CW       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BW       = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);
  localparam logic [BW-1:0] BIT_TOP  = BW'(WORD_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT_LO, S_SHIFT_HI, S_LE_SETUP, S_LE_PULSE, S_LE_HOLD
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [BW-1:0]          r_bit, w_bit_nxt;
  logic [WORD_WIDTH-1:0]  r_shreg, w_shreg_nxt;
  logic [WORD_WIDTH-1:0]  r_last;
  logic                   r_chain, w_chain_nxt, w_chain_sel;
  logic                   r_busy, r_overrun;
  logic                   w_accept, w_half_done;
  logic                   w_clk_nxt, w_sdi_nxt, w_le_nxt;
  logic [CHAIN_COUNT-1:0] w_mask;
  logic [CHAIN_COUNT-1:0] r_spi_clk, r_spi_sdi, r_spi_le;

  assign w_accept    = csrStrobe && (r_state == S_IDLE);
  assign w_half_done = (r_cnt == CNT_LAST);
  // With a single chain the select bit is ignored and chain 0 is always addressed.
  assign w_chain_sel = (CHAIN_COUNT > 1) ? csrData[30] : 1'b0;

  always_ff @(posedge sysClk) begin
    if (!sysReset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = w_half_done ? '0 : r_cnt + CW'(1);
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_accept) begin
          w_state_nxt = S_SHIFT_LO;
          w_bit_nxt   = BIT_TOP;
          w_shreg_nxt = csrData[WORD_WIDTH-1:0];
        end
      end
      S_SHIFT_LO: if (w_half_done) w_state_nxt = S_SHIFT_HI;
      S_SHIFT_HI: begin
        if (w_half_done) begin
          if (r_bit == '0) begin
            w_state_nxt = S_LE_SETUP;
          end else begin
            w_state_nxt = S_SHIFT_LO;
            w_bit_nxt   = r_bit - BW'(1);
            w_shreg_nxt = r_shreg << 1;
          end
        end
      end
      S_LE_SETUP: if (w_half_done) w_state_nxt = S_LE_PULSE;
      S_LE_PULSE: if (w_half_done) w_state_nxt = S_LE_HOLD;
      S_LE_HOLD:  if (w_half_done) w_state_nxt = S_IDLE;
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Pin levels are derived from the next state so they are registered alongside it.
  always_comb begin
    w_clk_nxt   = (w_state_nxt == S_SHIFT_HI);
    w_sdi_nxt   = ((w_state_nxt == S_SHIFT_LO) || (w_state_nxt == S_SHIFT_HI)) &&
                  w_shreg_nxt[WORD_WIDTH-1];
    w_le_nxt    = (w_state_nxt == S_LE_PULSE);
    w_chain_nxt = w_accept ? w_chain_sel : r_chain;
    w_mask      = '0;
    for (int c = 0; c < CHAIN_COUNT; c++)
      w_mask[c] = (c == int'(w_chain_nxt));
  end

  always_ff @(posedge sysClk) begin
    if (!sysReset_n) begin
      r_spi_clk <= '0;
      r_spi_sdi <= '0;
      r_spi_le  <= '0;
      r_chain   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_last    <= '0;
    end else begin
      r_spi_clk <= {CHAIN_COUNT{w_clk_nxt}} & w_mask;
      r_spi_sdi <= {CHAIN_COUNT{w_sdi_nxt}} & w_mask;
      r_spi_le  <= {CHAIN_COUNT{w_le_nxt}} & w_mask;
      r_chain   <= w_chain_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      if (w_accept) begin
        r_overrun <= 1'b0;
        r_last    <= csrData[WORD_WIDTH-1:0];
      end else if (csrStrobe) begin
        r_overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    status                   = '0;
    status[31]               = r_busy;
    status[30]               = r_overrun;
    status[29]               = r_chain;
    status[WORD_WIDTH-1:0]   = r_last;
  end

  assign spiClk = r_spi_clk;
  assign spiSdi = r_spi_sdi;
  assign spiLe  = r_spi_le;

endmodule

// File: tb/tb_afe_atten_spi_driver.sv
// Directed + randomized bench for afe_atten_spi_driver: default-rate instance (a)
// and a HALF=1 instance (b), checked against per-transfer waveform expectations.
module tb_afe_atten_spi_driver;

  localparam int SYS   = 99999001;
  localparam int HA    = (SYS + 2*5000000 - 1) / (2*5000000);
  localparam int HB    = 1;
  localparam int WW    = 8;

  logic        clk = 1'b0;
  logic        rst_n, stb_a, stb_b;
  logic [31:0] data;
  logic [31:0] st_a, st_b;
  logic [1:0]  sclk_a, sdi_a, le_a, sclk_b, sdi_b, le_b;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  afe_atten_spi_driver #(.SYSCLK_RATE(SYS), .SPI_RATE(5000000), .WORD_WIDTH(WW), .CHAIN_COUNT(2)) u_a (
    .sysClk(clk), .sysReset_n(rst_n), .csrStrobe(stb_a), .csrData(data),
    .status(st_a), .spiClk(sclk_a), .spiSdi(sdi_a), .spiLe(le_a));

  afe_atten_spi_driver #(.SYSCLK_RATE(SYS), .SPI_RATE(SYS), .WORD_WIDTH(WW), .CHAIN_COUNT(2)) u_b (
    .sysClk(clk), .sysReset_n(rst_n), .csrStrobe(stb_b), .csrData(data),
    .status(st_b), .spiClk(sclk_b), .spiSdi(sdi_b), .spiLe(le_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One CSR write, then watch the selected instance until busy drops.
  // ovr_at>0 fires a second (ignored) strobe on that busy cycle.
  task automatic xfer(input bit sel, input logic [31:0] d, input int ovr_at, input string tag);
    int half = sel ? HB : HA;
    int blen = half * (2*WW + 3);
    int ch   = int'(d[30]);
    logic [1:0]  c, s, l;
    logic [31:0] st;
    logic [7:0]  bits = '0;
    logic        prev_clk = 1'b0, prev_sdi = 1'b0;
    int edges = 0, le_cyc = 0, busy = 0, bad_other = 0, bad_sdi = 0;
    bit done = 0;

    @(posedge clk); #1;
    data = d;
    if (sel) stb_b = 1'b1; else stb_a = 1'b1;
    @(posedge clk); #1;
    stb_a = 1'b0; stb_b = 1'b0;
    st = sel ? st_b : st_a;
    chk({tag, "_acc_busy"},    32'(st[31]), 32'd1);
    chk({tag, "_acc_overrun"}, 32'(st[30]), 32'd0);
    chk({tag, "_acc_chain"},   32'(st[29]), 32'(ch));
    chk({tag, "_acc_word"},    32'(st[7:0]), 32'(d[7:0]));

    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      @(negedge clk);
      c  = sel ? sclk_b : sclk_a;
      s  = sel ? sdi_b  : sdi_a;
      l  = sel ? le_b   : le_a;
      st = sel ? st_b   : st_a;
      stb_a = 1'b0; stb_b = 1'b0; data = d;
      if (!st[31]) begin
        done = 1;
      end else begin
        busy++;
        if (c[ch] && !prev_clk) begin
          bits = {bits[6:0], s[ch]};
          edges++;
        end
        if (c[ch] && prev_clk && (s[ch] !== prev_sdi)) bad_sdi++;
        if (l[ch]) le_cyc++;
        if (c[1-ch] | s[1-ch] | l[1-ch]) bad_other++;
        prev_clk = c[ch];
        prev_sdi = s[ch];
        if (busy == ovr_at) begin
          data = ~d;
          if (sel) stb_b = 1'b1; else stb_a = 1'b1;
        end
      end
    end
    stb_a = 1'b0; stb_b = 1'b0;

    chk({tag, "_done"},      32'(done), 32'd1);
    chk({tag, "_bits"},      32'(bits), 32'(d[7:0]));
    chk({tag, "_edges"},     32'(edges), 32'd8);
    chk({tag, "_le_cycles"}, 32'(le_cyc), 32'(half));
    chk({tag, "_busy_len"},  32'(busy), 32'(blen));
    chk({tag, "_other"},     32'(bad_other), 32'd0);
    chk({tag, "_sdi_hold"},  32'(bad_sdi), 32'd0);
    chk({tag, "_end_busy"},  32'(st[31]), 32'd0);
    chk({tag, "_overrun"},   32'(st[30]), 32'(ovr_at > 0));
    chk({tag, "_end_word"},  32'(st[7:0]), 32'(d[7:0]));
    chk({tag, "_end_chain"}, 32'(st[29]), 32'(ch));
  endtask

  initial begin
    int          cnt;
    bit          hit;
    logic        prev;
    logic [31:0] rd;
    int          le_seen;

    rst_n = 1'b0; stb_a = 1'b0; stb_b = 1'b0; data = '0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_status_a", st_a, 32'd0);
    chk("rst_status_b", st_b, 32'd0);
    chk("rst_pins_a", {26'd0, sclk_a, sdi_a, le_a}, 32'd0);
    chk("rst_pins_b", {26'd0, sclk_b, sdi_b, le_b}, 32'd0);
    rst_n = 1'b1;

    xfer(0, 32'h0000_00A5, -1, "a5_ch0");
    xfer(0, 32'h4000_003C, -1, "3c_ch1");
    xfer(0, 32'h0000_005A, 50, "ovr50");
    xfer(0, 32'h4000_0012, -1, "clr_ovr");
    xfer(0, 32'h4000_0081, HA*(2*WW+3), "ovr_edge");

    // Reset landing while the addressed chain is high for the 5th bit (bit 3).
    @(posedge clk); #1;
    data = 32'h0000_00A5; stb_a = 1'b1;
    @(posedge clk); #1;
    stb_a = 1'b0;
    cnt = 0; hit = 0; prev = 1'b0;
    for (int cyc = 0; cyc < 400 && !hit; cyc++) begin
      @(negedge clk);
      if (sclk_a[0] && !prev) cnt++;
      prev = sclk_a[0];
      if (cnt == 5) hit = 1;
    end
    chk("rst_mid_reached", 32'(hit), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_pins", {26'd0, sclk_a, sdi_a, le_a}, 32'd0);
    chk("rst_mid_status", st_a, 32'd0);
    rst_n = 1'b1;
    le_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (le_a != 2'b00 || st_a[31]) le_seen++;
    end
    chk("rst_mid_no_le", 32'(le_seen), 32'd0);
    xfer(0, 32'h0000_00C3, -1, "post_rst");

    for (int i = 0; i < 6; i++) begin
      rd = $urandom;
      xfer(0, rd, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, HA*(2*WW+3) - 1)) : -1,
           $sformatf("rnd%0d", i));
    end

    xfer(1, 32'h0000_00FF, -1, "fast_ff");
    xfer(1, 32'h4000_0000 | 32'($urandom_range(0, 255)), 7, "fast_ovr");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
